apb_master_sram_loader: RTL and testbench

APB_MASTER_SRAM_LOADER -- requirements
Module: apb_master_sram_loader

---
 rtl/apb_sram_loader_pkg.sv | 42 ++++
 rtl/apb_master_phase.sv | 70 +++++++
 rtl/apb_master_sram_loader.sv | 171 +++++++++++++++++
 tb/tb_apb_master_sram_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sram_loader_pkg.sv
// Shared state encodings, register-map offsets and helpers for the APB SRAM loader.
// Optional checksum feature: APB_SRAM_LOADER_CHECKSUM_EN (see apb_master_sram_loader.sv).
package apb_sram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SETADDR,
    ST_COLLECT,
    ST_WRDATA,
    ST_RELEASE,
    ST_DRAIN
  } loader_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } phase_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_wr_t;

  localparam logic [31:0] REG_ADDR_OFS = 32'h0000_0000;
  localparam logic [31:0] REG_DATA_OFS = 32'h0000_0004;
  localparam logic [31:0] REG_CTRL_OFS = 32'h0000_0008;
  localparam logic [31:0] CTRL_HOLD    = 32'h0000_0001;
  localparam logic [31:0] CTRL_RUN     = 32'h0000_0000;

  // Little-endian lane insert: lane 0 lands in bits [7:0].
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/apb_master_phase.sv
// APB write sequencer: start in idle -> one setup cycle -> access held until pready; done/err pulse on completion.
// Start is only taken while idle; address/data are latched at start and held until the access completes.
module apb_master_phase
  import apb_sram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_pready,
  input  logic        i_perr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_paddr,
  output logic [31:0] o_pwdata,
  output logic        o_idle,
  output logic        o_done,
  output logic        o_err
);

  phase_state_t r_state;
  phase_state_t w_next;
  apb_wr_t      r_req;
  logic         w_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= PH_IDLE;
      r_req   <= '0;
    end else if (clk__enable) begin
      r_state <= w_next;
      if (r_state == PH_IDLE && i_start) begin
        r_req.addr  <= i_addr;
        r_req.wdata <= i_wdata;
      end else if (w_done) begin
        // Return the bus to all-zero between transfers.
        r_req <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      PH_IDLE:   if (i_start) w_next = PH_SETUP;
      PH_SETUP:  w_next = PH_ACCESS;
      PH_ACCESS: begin
        if (i_pready) begin
          w_next = PH_IDLE;
          w_done = 1'b1;
        end
      end
      default:   w_next = PH_IDLE;
    endcase
  end

  assign o_psel    = (r_state != PH_IDLE);
  assign o_penable = (r_state == PH_ACCESS);
  assign o_pwrite  = (r_state != PH_IDLE);
  assign o_paddr   = r_req.addr;
  assign o_pwdata  = r_req.wdata;
  assign o_idle    = (r_state == PH_IDLE);
  assign o_done    = w_done & clk__enable;
  assign o_err     = w_done & clk__enable & i_perr;

endmodule

// File: rtl/apb_master_sram_loader.sv
// Streams bytes into SRAM over APB (hold CPU, set address, word writes, release); >=2 cycles byte-to-write, byte_ready only in COLLECT/DRAIN.
// Define APB_SRAM_LOADER_CHECKSUM_EN to accumulate a 32-bit wrapping sum of written words on checksum.
module apb_master_sram_loader
  import apb_sram_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] apb_request__paddr,
  output logic        apb_request__penable,
  output logic        apb_request__psel,
  output logic        apb_request__pwrite,
  output logic [31:0] apb_request__pwdata,
  input  logic [31:0] apb_response__prdata,
  input  logic        apb_response__pready,
  input  logic        apb_response__perr,
  output logic        loader_busy,
  output logic        loader_error,
  output logic [15:0] words_loaded,
  output logic [31:0] checksum
);

  loader_state_t r_state;
  loader_state_t w_next;
  logic [31:0]   r_word;
  logic [1:0]    r_lane;
  logic          r_last_word;
  logic          r_error;
  logic [15:0]   r_words;

  logic          w_start;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_idle;
  logic          w_done;
  logic          w_err;
  logic          w_byte_rdy;
  logic          w_accept;
  logic          w_wr_ok;
  logic          w_load_start;
  logic          w_unused;

  // Read data is never consumed: every transfer is a write.
  assign w_unused = ^apb_response__prdata;

  assign w_byte_rdy   = ((r_state == ST_COLLECT) || (r_state == ST_DRAIN)) && clk__enable;
  assign w_accept     = byte_valid & w_byte_rdy;
  assign w_wr_ok      = (r_state == ST_WRDATA) && w_done && !w_err;
  assign w_load_start = (r_state == ST_IDLE) && (w_next == ST_HOLD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_lane      <= '0;
      r_last_word <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
    end else if (clk__enable) begin
      r_state <= w_next;
      if (w_err) r_error <= 1'b1;
      if (w_load_start) begin
        r_words <= '0;
      end else if (w_wr_ok) begin
        r_words <= r_words + 16'd1;
      end
      if (r_state == ST_COLLECT && w_accept) begin
        // Lane 0 starts a fresh word so a short final word is zero-padded.
        r_word      <= place_byte((r_lane == 2'd0) ? 32'h0 : r_word, r_lane, byte_data);
        r_lane      <= byte_last ? 2'd0 : r_lane + 2'd1;
        r_last_word <= byte_last;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (byte_valid) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_start = w_idle;
        w_addr  = BASE_ADDR + REG_CTRL_OFS;
        w_wdata = CTRL_HOLD;
        if (w_done) w_next = ST_SETADDR;
      end
      ST_SETADDR: begin
        w_start = w_idle;
        w_addr  = BASE_ADDR + REG_ADDR_OFS;
        w_wdata = 32'h0;
        if (w_done) w_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_accept && (r_lane == 2'd3 || byte_last)) w_next = ST_WRDATA;
      end
      ST_WRDATA: begin
        w_start = w_idle;
        w_addr  = BASE_ADDR + REG_DATA_OFS;
        w_wdata = r_word;
        if (w_done) w_next = r_last_word ? ST_RELEASE : ST_COLLECT;
      end
      ST_RELEASE: begin
        w_start = w_idle;
        w_addr  = BASE_ADDR + REG_CTRL_OFS;
        w_wdata = CTRL_RUN;
        if (w_done) w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (w_accept && byte_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // A failed write leaves the processor held and flushes the rest of the stream.
    if (w_err) w_next = ST_DRAIN;
  end

  apb_master_phase u_phase (
    .clk         (clk),
    .clk__enable (clk__enable),
    .reset_n     (reset_n),
    .i_start     (w_start),
    .i_addr      (w_addr),
    .i_wdata     (w_wdata),
    .i_pready    (apb_response__pready),
    .i_perr      (apb_response__perr),
    .o_psel      (apb_request__psel),
    .o_penable   (apb_request__penable),
    .o_pwrite    (apb_request__pwrite),
    .o_paddr     (apb_request__paddr),
    .o_pwdata    (apb_request__pwdata),
    .o_idle      (w_idle),
    .o_done      (w_done),
    .o_err       (w_err)
  );

`ifdef APB_SRAM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (clk__enable) begin
      if (w_load_start) begin
        r_checksum <= '0;
      end else if (w_wr_ok) begin
        r_checksum <= r_checksum + r_word;
      end
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif

  assign byte_ready   = w_byte_rdy;
  assign loader_busy  = (r_state != ST_IDLE);
  assign loader_error = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_apb_master_sram_loader.sv
// Randomized bench for apb_master_sram_loader: byte-stream driver, APB responder/monitor, transfer-list reference model.
// Checksum expectations follow APB_SRAM_LOADER_CHECKSUM_EN.
module tb_apb_master_sram_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        clk__enable;
  logic        reset_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] paddr;
  logic        penable;
  logic        psel;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        perr;
  logic        loader_busy;
  logic        loader_error;
  logic [15:0] words_loaded;
  logic [31:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  int          acc_q[$];
  int          err_xfer;
  int          xfer_idx;
  int          force_wait;
  int          wait_left;
  int          acc_cnt;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  bit          en_rand;
  bit          m_err;
  logic [15:0] m_words;
  logic [31:0] m_sum;

  apb_master_sram_loader #(.BASE_ADDR(BASE)) dut (
    .clk                  (clk),
    .clk__enable          (clk__enable),
    .reset_n              (reset_n),
    .byte_valid           (byte_valid),
    .byte_data            (byte_data),
    .byte_last            (byte_last),
    .byte_ready           (byte_ready),
    .apb_request__paddr   (paddr),
    .apb_request__penable (penable),
    .apb_request__psel    (psel),
    .apb_request__pwrite  (pwrite),
    .apb_request__pwdata  (pwdata),
    .apb_response__prdata (prdata),
    .apb_response__pready (pready),
    .apb_response__perr   (perr),
    .loader_busy          (loader_busy),
    .loader_error         (loader_error),
    .words_loaded         (words_loaded),
    .checksum             (checksum)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    clk__enable = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // APB responder and monitor; decisions made at negedge apply at the next posedge.
  initial forever begin
    @(negedge clk);
    pready = 1'b0;
    perr   = 1'b0;
    prdata = $urandom;
    if (reset_n) begin
      if (psel && !penable) begin
        wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        acc_cnt   = 0;
        s_addr    = paddr;
        s_data    = pwdata;
      end
      if (psel && penable) begin
        check_eq("acc_hold", {pwrite, paddr, pwdata}, {1'b1, s_addr, s_data});
        if (wait_left == 0) begin
          pready = 1'b1;
          perr   = (xfer_idx == err_xfer);
        end
      end
      if (psel) check_eq("rdy_in_xfer", byte_ready, 0);
      else      check_eq("bus_idle", {penable, paddr, pwdata}, 0);
      if (clk__enable && psel && penable) begin
        acc_cnt++;
        if (pready) begin
          obs_q.push_back({perr, paddr, pwdata});
          acc_q.push_back(acc_cnt);
          xfer_idx++;
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Expected write list: hold, address, one write per 4 bytes (zero-padded), release; cut at an error.
  function automatic void model_load();
    logic [64:0] plan[$];
    logic [31:0] w;
    plan.push_back({1'b0, BASE + 32'h8, 32'h1});
    plan.push_back({1'b0, BASE + 32'h0, 32'h0});
    for (int i = 0; i < stim_q.size(); i += 4) begin
      w = 32'h0;
      for (int j = 0; j < 4 && i + j < stim_q.size(); j++)
        w = w | (32'(stim_q[i + j]) << (8 * j));
      plan.push_back({1'b0, BASE + 32'h4, w});
    end
    plan.push_back({1'b0, BASE + 32'h8, 32'h0});
    exp_q.delete();
    m_words = 16'h0;
    m_sum   = 32'h0;
    for (int k = 0; k < plan.size(); k++) begin
      if (k == err_xfer) begin
        exp_q.push_back({1'b1, plan[k][63:0]});
        m_err = 1'b1;
        break;
      end
      exp_q.push_back(plan[k]);
      if (plan[k][63:32] == BASE + 32'h4) begin
        m_words = m_words + 16'd1;
        m_sum   = m_sum + plan[k][31:0];
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!byte_ready && n < 400);
    if (!byte_ready) check_eq("byte_timeout", byte_ready, 1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic run_load(input string tag);
    int n;
    obs_q.delete();
    acc_q.delete();
    xfer_idx = 0;
    model_load();
    for (int i = 0; i < stim_q.size(); i++)
      send_byte(stim_q[i], i == stim_q.size() - 1);
    n = 0;
    while (loader_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, loader_busy, 0);
    check_eq({tag, "_nxfer"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check_eq($sformatf("%s_xfer%0d", tag, k), obs_q[k], exp_q[k]);
    check_eq({tag, "_words"}, words_loaded, m_words);
    check_eq({tag, "_error"}, loader_error, m_err);
`ifdef APB_SRAM_LOADER_CHECKSUM_EN
    check_eq({tag, "_csum"}, checksum, m_sum);
`else
    check_eq({tag, "_csum"}, checksum, 0);
`endif
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq(tag, {psel, penable, pwrite, paddr, loader_busy, loader_error, words_loaded, checksum}, 0);
    reset_n = 1'b1;
    m_err   = 1'b0;
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    clk__enable = 1'b1;
    byte_valid  = 1'b0;
    byte_data   = 8'h0;
    byte_last   = 1'b0;
    pready      = 1'b0;
    perr        = 1'b0;
    prdata      = 32'h0;
    en_rand     = 1'b0;
    force_wait  = -1;
    err_xfer    = -1;
    xfer_idx    = 0;
    m_err       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_bus", {psel, penable, pwrite, paddr, pwdata}, 0);
    check_eq("rst_stat", {byte_ready, loader_busy, loader_error, words_loaded, checksum}, 0);
    reset_n = 1'b1;

    // Two full words, zero wait states.
    force_wait = 0;
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load("t_full");
    check_eq("t_full_w0", obs_q[2], {1'b0, 32'h1004, 32'h44332211});
    check_eq("t_full_w1", obs_q[3], {1'b0, 32'h1004, 32'h88776655});
    check_eq("t_full_rel", obs_q[4], {1'b0, 32'h1008, 32'h0});
    check_eq("t_full_cnt", words_loaded, 16'd2);

    // Partial final word is zero-padded.
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load("t_part");
    check_eq("t_part_w1", obs_q[3], {1'b0, 32'h1004, 32'h0000_00EE});

    // Three wait states on every access: four access cycles each.
    force_wait = 3;
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load("t_wait");
    foreach (acc_q[k]) check_eq($sformatf("t_wait_acc%0d", k), acc_q[k], 4);
    force_wait = -1;

    // Error on the second data write: no release, stream drained, sticky error.
    stim_q.delete();
    for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
    err_xfer = 3;
    run_load("t_err");
    check_eq("t_err_n", obs_q.size(), 4);
    err_xfer = -1;

    // Reset after two bytes of the second word.
    obs_q.delete();
    xfer_idx = 0;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    check_eq("t_rst_pre", words_loaded, 16'd1);
    apply_reset("t_rst_post");
    stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load("t_csum");
    check_eq("t_csum_hold", obs_q[0], {1'b0, 32'h1008, 32'h1});
`ifdef APB_SRAM_LOADER_CHECKSUM_EN
    check_eq("t_csum_val", checksum, 32'h0000_0001);
`else
    check_eq("t_csum_val", checksum, 32'h0);
`endif

    // Randomized loads: lengths, wait states, clock-enable gaps, error points.
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 20);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
      err_xfer = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (n + 3) / 4)) : -1;
      en_rand  = ($urandom_range(0, 1) == 1);
      run_load($sformatf("r%0d", t));
      if ($urandom_range(0, 4) == 0) apply_reset($sformatf("r%0d_rst", t));
    end
    en_rand  = 1'b0;
    err_xfer = -1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
